hex_scan_ctrl: RTL and testbench
================================

Name: hex_scan_ctrl

Overview:
- Owns a 6-nibble display buffer and shares one external combinational hex-to-7-segment decoder across HEX5..HEX0 by time-multiplexing it.
- Nibbles are loaded from SW. The buffer optionally scrolls left across the displays on a prescaled tick.
- Each decoded pattern is captured into a per-digit output register.
- Sits between the board switches/keys and the HEX outputs, with the decoder instance as the shared resource.

Parameters:
- TICK_DIV, 25000000, CLOCK_50 cycles per scroll tick (0.5 s at 50 MHz); legal range 2 to 2^26.

Ports:
- CLOCK_50  in  1  system clock, all state on rising edge
- KEY0  in  1  reset, asynchronous, active-low
- SW  in  4  nibble to load
- load  in  1  single-cycle synchronous strobe: shift SW into buffer
- run  in  1  level: 1 = scroll on tick, 0 = hold
- seg_code  out  4  nibble presented to the shared decoder
- seg_leds  in  7  decoder output, active-low segments, combinational from seg_code
- HEX0..HEX5  out  7 each  registered active-low segment patterns; HEX5 is leftmost
- busy  out  1  1 while a scan is in progress

Behaviour:
- Reset (KEY0=0, asynchronous):
  - buf[0..5]=0, prescaler=0, state=IDLE, idx=0, dirty=1.
  - HEX0..HEX5=7'b1111111 (blank), busy=0, seg_code=0.
  - Reset applied mid-scan aborts the scan immediately; all values return to the above.
- Buffer mapping: buf[i] drives HEXi.
- Load (load=1 at an edge):
  - buf[i+1]<=buf[i] for i=0..4; buf[0]<=SW; old buf[5] is discarded.
  - Sets dirty.
- Prescaler:
  - While run=1, counts 0..TICK_DIV-1 and wraps. tick=1 in the cycle where prescaler==TICK_DIV-1.
  - While run=0, prescaler is cleared to 0 and no tick occurs.
- Rotate (tick=1 and load=0):
  - buf[i+1]<=buf[i] for i=0..4; buf[0]<=buf[5] (wrap).
  - Sets dirty.
- Simultaneous load and tick: load wins and that rotate is lost; the prescaler still wraps.
- FSM:
  - IDLE: busy=0, seg_code=0. If dirty=1, go to SCAN with idx=0 and clear dirty.
  - SCAN: busy=1, seg_code=buf[idx]. At each edge HEX[idx]<=seg_leds, then:
    - idx<5: idx+1.
    - idx==5 and dirty==0: go to IDLE.
    - idx==5 and dirty==1: idx=0, clear dirty, stay in SCAN.
  - A buffer change during SCAN sets dirty. Digits not yet scanned show the new buffer contents; digits already scanned are corrected by the rescan.
- Latency:
  - Buffer changes at edge k with FSM in IDLE: SCAN starts in the cycle after edge k+1.
  - HEX0 is updated at edge k+2; HEX5 at edge k+7.
  - A full refresh is 6 cycles.
- After reset release, the first scan displays "000000" by the 7th edge.
- dirty set and cleared in the same cycle: set wins.
- The block never drives HEX registers outside SCAN.

Test Plan:
- Reset then release, decoder model attached, SW=0 -> within 7 edges HEX0..HEX5=7'b1000000; busy high for exactly 6 cycles, then 0.
- Six load pulses with SW=1,2,3,4,5,6, run=0 -> final HEX5..HEX0 show 1,2,3,4,5,6 (HEX0=7'b0000010, HEX5=7'b1111001); each load triggers a rescan.
- TICK_DIV=4, buffer 1..6 loaded, run=1 -> tick every 4 cycles; after first tick HEX5..HEX0 = 2,3,4,5,6,1; after 6 ticks the buffer equals the original.
- load pulse coincident with tick (TICK_DIV=4, run=1) -> buffer shows only the load shift, no rotate; prescaler wraps to 0.
- load asserted at idx=3 mid-scan -> dirty set; FSM goes idx=5 -> idx=0 without returning to IDLE; busy stays high 12 consecutive cycles; final HEX matches the new buffer.
- KEY0 pulsed low mid-scan at idx=2 -> HEX0..HEX5=7'b1111111, busy=0 asynchronously; after release, full scan of "000000" completes within 7 edges.

Source files
------------

// File: rtl/hex_scan_ctrl.sv
// hex_scan_ctrl: six-nibble display buffer scanned through one shared hex-to-7-segment decoder
module hex_scan_ctrl #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic [3:0] SW,
  input  logic       load,
  input  logic       run,
  output logic [3:0] seg_code,
  input  logic [6:0] seg_leds,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  logic [3:0]    buf_q [6];
  logic [3:0]    buf_d [6];
  logic [6:0]    hex_q [6];
  logic [6:0]    hex_d [6];
  logic [0:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          dirty_q, dirty_d;
  logic          buf_chg;
  logic          dirty_clr;

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

  // Scroll prescaler: free-runs while run is high, held at zero otherwise
  always_comb begin
    tick    = run && (presc_q == TICK_LAST);
    presc_d = (!run || tick) ? '0 : presc_q + PW'(1);
  end

  // Buffer update: a load shifts SW in and takes priority over a rotate on the same tick
  always_comb begin
    buf_chg = load || tick;
    for (int i = 0; i < 6; i++) buf_d[i] = buf_q[i];
    if (buf_chg) begin
      buf_d[0] = load ? SW : buf_q[5];
      for (int i = 1; i < 6; i++) buf_d[i] = buf_q[i-1];
    end
  end

  // Scan FSM: walks idx 0..5 capturing decoder output, rescans if the buffer moved meanwhile
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dirty_clr = 1'b0;
    for (int i = 0; i < 6; i++) hex_d[i] = hex_q[i];
    busy     = (state_q == S_SCAN);
    seg_code = busy ? buf_q[idx_q] : 4'h0;
    if (state_q == S_IDLE) begin
      if (dirty_q) begin
        state_d   = S_SCAN;
        idx_d     = 3'd0;
        dirty_clr = 1'b1;
      end
    end else begin
      hex_d[idx_q] = seg_leds;
      if (idx_q != 3'd5) begin
        idx_d = idx_q + 3'd1;
      end else if (dirty_q) begin
        idx_d     = 3'd0;
        dirty_clr = 1'b1;
      end else begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    end
    dirty_d = buf_chg ? 1'b1 : (dirty_clr ? 1'b0 : dirty_q);
  end

  // State registers; reset blanks the display and forces an initial refresh
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      presc_q <= '0;
      state_q <= S_IDLE;
      idx_q   <= 3'd0;
      dirty_q <= 1'b1;
      for (int i = 0; i < 6; i++) begin
        buf_q[i] <= 4'h0;
        hex_q[i] <= BLANK;
      end
    end else begin
      presc_q <= presc_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      dirty_q <= dirty_d;
      for (int i = 0; i < 6; i++) begin
        buf_q[i] <= buf_d[i];
        hex_q[i] <= hex_d[i];
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// tb_hex_scan_ctrl: randomized scenario bench for hex_scan_ctrl against a 24-bit word model
module tb_hex_scan_ctrl;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0 = 1'b0;
  logic [3:0] SW = 4'h0;
  logic       load = 1'b0;
  logic       run = 1'b0;
  logic [3:0] seg_code;
  logic [6:0] seg_leds;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic       busy;
  logic [6:0] hex_obs [6];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] mw = '0;
  int          run_len = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'h0: dec = 7'b1000000; 4'h1: dec = 7'b1111001; 4'h2: dec = 7'b0100100; 4'h3: dec = 7'b0110000;
      4'h4: dec = 7'b0011001; 4'h5: dec = 7'b0010010; 4'h6: dec = 7'b0000010; 4'h7: dec = 7'b1111000;
      4'h8: dec = 7'b0000000; 4'h9: dec = 7'b0010000; 4'hA: dec = 7'b0001000; 4'hB: dec = 7'b0000011;
      4'hC: dec = 7'b1000110; 4'hD: dec = 7'b0100001; 4'hE: dec = 7'b0000110; default: dec = 7'b0001110;
    endcase
  endfunction

  assign seg_leds   = dec(seg_code);
  assign hex_obs[0] = HEX0;
  assign hex_obs[1] = HEX1;
  assign hex_obs[2] = HEX2;
  assign hex_obs[3] = HEX3;
  assign hex_obs[4] = HEX4;
  assign hex_obs[5] = HEX5;

  hex_scan_ctrl #(.TICK_DIV(4)) dut (
    .CLOCK_50(CLOCK_50), .KEY0(KEY0), .SW(SW), .load(load), .run(run),
    .seg_code(seg_code), .seg_leds(seg_leds),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .busy(busy)
  );

  // One clock: drive inputs, advance the word model, observe 1 time unit after the edge.
  // Model: nibble i of mw is digit i; every 4th consecutive run cycle is a tick.
  task automatic step(input logic l, input logic [3:0] s, input logic r);
    load = l;
    SW = s;
    run = r;
    run_len = r ? run_len + 1 : 0;
    if (l) mw = {mw[19:0], s};
    else if (r && (run_len % 4 == 0)) mw = {mw[19:0], mw[23:20]};
    @(posedge CLOCK_50);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    while (busy && k < 40) begin
      step(0, 0, 0);
      k++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle_timeout busy got %b expected 0", tag, busy);
    end
  endtask

  task automatic test_reset();
    int nb = 0;
    KEY0 = 1'b0;
    @(posedge CLOCK_50);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || seg_code !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_outputs busy/seg_code got %b/%h expected 0/0", busy, seg_code);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'b1111111) begin
        n_bad++;
        $display("FAIL reset_blank HEX%0d got %b expected 1111111", i, hex_obs[i]);
      end
    end
    KEY0 = 1'b1;
    mw = '0;
    run_len = 0;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 0);
      nb += int'(busy);
    end
    n_cmp++;
    if (nb != 6 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_scan busy_cycles got %0d (busy now %b) expected 6 (busy now 0)", nb, busy);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'b1000000) begin
        n_bad++;
        $display("FAIL reset_zero HEX%0d got %b expected 1000000", i, hex_obs[i]);
      end
    end
  endtask

  task automatic test_loads();
    for (int v = 1; v <= 6; v++) begin
      step(1, 4'(v), 0);
      n_cmp++;
      if (busy !== 1'b0) begin
        n_bad++;
        $display("FAIL load_latency busy one edge after load got %b expected 0", busy);
      end
      step(0, 0, 0);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_bad++;
        $display("FAIL load_rescan busy two edges after load got %b expected 1", busy);
      end
      wait_idle("loads");
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (hex_obs[i] !== dec(mw[4*i +: 4])) begin
          n_bad++;
          $display("FAIL loads_%0d HEX%0d got %b expected %b", v, i, hex_obs[i], dec(mw[4*i +: 4]));
        end
      end
    end
    n_cmp++;
    if (HEX0 !== 7'b0000010 || HEX5 !== 7'b1111001) begin
      n_bad++;
      $display("FAIL loads_final HEX0/HEX5 got %b/%b expected 0000010/1111001", HEX0, HEX5);
    end
  endtask

  task automatic test_rotate();
    logic [23:0] orig = mw;
    int nb = 0;
    int first = 0;
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 1);
      nb += int'(busy);
    end
    for (int c = 0; c < 2; c++) begin
      step(0, 0, 0);
      nb += int'(busy);
    end
    n_cmp++;
    if (nb != 0) begin
      n_bad++;
      $display("FAIL rotate_early busy cycles after 3 run cycles got %0d expected 0", nb);
    end
    for (int c = 1; c <= 6; c++) begin
      step(0, 0, c <= 4);
      if (busy && first == 0) first = c;
    end
    n_cmp++;
    if (first != 5) begin
      n_bad++;
      $display("FAIL rotate_tick first busy step got %0d expected 5", first);
    end
    wait_idle("rotate1");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== dec(mw[4*i +: 4])) begin
        n_bad++;
        $display("FAIL rotate1 HEX%0d got %b expected %b", i, hex_obs[i], dec(mw[4*i +: 4]));
      end
    end
    n_cmp++;
    if (HEX0 !== dec(4'h1) || HEX5 !== dec(4'h2)) begin
      n_bad++;
      $display("FAIL rotate1_ends HEX0/HEX5 got %b/%b expected %b/%b", HEX0, HEX5, dec(4'h1), dec(4'h2));
    end
    for (int c = 0; c < 20; c++) step(0, 0, 1);
    wait_idle("rotate6");
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== dec(orig[4*i +: 4])) begin
        n_bad++;
        $display("FAIL rotate6 HEX%0d got %b expected %b", i, hex_obs[i], dec(orig[4*i +: 4]));
      end
    end
  endtask

  task automatic test_load_tick();
    for (int p = 0; p < 2; p++) begin
      logic [3:0] s = 4'($urandom);
      for (int c = 0; c < 3; c++) step(0, 0, 1);
      step(1, s, 1);
      if (p == 1) for (int c = 0; c < 4; c++) step(0, 0, 1);
      wait_idle("load_tick");
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (hex_obs[i] !== dec(mw[4*i +: 4])) begin
          n_bad++;
          $display("FAIL load_tick_p%0d HEX%0d got %b expected %b", p, i, hex_obs[i], dec(mw[4*i +: 4]));
        end
      end
    end
  endtask

  task automatic test_midscan();
    int nb = 0;
    int k = 0;
    step(1, 4'($urandom), 0);
    nb += int'(busy);
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0);
      nb += int'(busy);
    end
    n_cmp++;
    if (seg_code !== mw[15:12]) begin
      n_bad++;
      $display("FAIL midscan_idx3 seg_code got %h expected %h", seg_code, mw[15:12]);
    end
    step(1, 4'($urandom), 0);
    nb += int'(busy);
    while (busy && k < 30) begin
      step(0, 0, 0);
      nb += int'(busy);
      k++;
    end
    n_cmp++;
    if (nb != 12) begin
      n_bad++;
      $display("FAIL midscan_busy consecutive busy cycles got %0d expected 12", nb);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== dec(mw[4*i +: 4])) begin
        n_bad++;
        $display("FAIL midscan HEX%0d got %b expected %b", i, hex_obs[i], dec(mw[4*i +: 4]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb = 0;
    step(1, 4'($urandom_range(15, 1)), 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0);
    KEY0 = 1'b0;
    #2;
    n_cmp++;
    if (busy !== 1'b0 || seg_code !== 4'h0) begin
      n_bad++;
      $display("FAIL async_reset busy/seg_code got %b/%h expected 0/0", busy, seg_code);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'b1111111) begin
        n_bad++;
        $display("FAIL async_reset HEX%0d got %b expected 1111111", i, hex_obs[i]);
      end
    end
    KEY0 = 1'b1;
    mw = '0;
    run_len = 0;
    for (int c = 0; c < 7; c++) begin
      step(0, 0, 0);
      nb += int'(busy);
    end
    n_cmp++;
    if (nb != 6 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_rescan busy_cycles got %0d (busy now %b) expected 6 (busy now 0)", nb, busy);
    end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (hex_obs[i] !== 7'b1000000) begin
        n_bad++;
        $display("FAIL reset_mid_zero HEX%0d got %b expected 1000000", i, hex_obs[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 60; c++)
        step(($urandom % 4) == 0, 4'($urandom), ($urandom % 3) != 0);
      wait_idle("random");
      for (int i = 0; i < 6; i++) begin
        n_cmp++;
        if (hex_obs[i] !== dec(mw[4*i +: 4])) begin
          n_bad++;
          $display("FAIL random_r%0d HEX%0d got %b expected %b", r, i, hex_obs[i], dec(mw[4*i +: 4]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_rotate();
    test_load_tick();
    test_midscan();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
